// File: rtl/assign_y0_y1_pkg.sv
// Shared constants for the assign_y0_y1 full-adder block.
package assign_y0_y1_pkg;

    // Width of the {Y1,Y0} result: a count of 0..3 ones.
    localparam int RES_W = 2;

    // Value the registered result takes while rst_n is low.
    localparam logic [RES_W-1:0] RES_RST = 2'b00;

endpackage : assign_y0_y1_pkg

// File: rtl/assign_y0_y1_maj_par3.sv
// Three-input majority and odd parity: the carry and sum of a full adder.
module maj_par3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic maj,
    output logic par
);

    // Carry is set when at least two inputs are high; sum is their parity.
    always_comb begin
        maj = (a & b) | (a & c) | (b & c);
        par = a ^ b ^ c;
    end

endmodule : maj_par3

// File: rtl/assign_y0_y1.sv
// Counts the ones among a, b, c as {Y1,Y0}, with an optional output register.
module assign_y0_y1
    import assign_y0_y1_pkg::*;
#(
    parameter bit REGISTERED = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic Y1,
    output logic Y0
);

    logic maj;
    logic par;

    maj_par3 u_maj_par3 (
        .a   (a),
        .b   (b),
        .c   (c),
        .maj (maj),
        .par (par)
    );

    if (REGISTERED) begin : g_reg
        logic [RES_W-1:0] res_d;
        logic [RES_W-1:0] res_q;

        // Next result is simply the current carry/sum pair.
        always_comb begin
            res_d = {maj, par};
        end

        // Output register; reset clears it without waiting for a clock edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= RES_RST;
            end else begin
                res_q <= res_d;
            end
        end

        assign {Y1, Y0} = res_q;
    end else begin : g_comb
        // Clock and reset play no part in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst_n;

        assign {Y1, Y0} = {maj, par};
    end

endmodule : assign_y0_y1

// File: tb/tb_assign_y0_y1.sv
// Scoreboard bench for assign_y0_y1: registered and combinational builds side by side.
module tb_assign_y0_y1;

    logic clk;
    logic rst_n;
    logic a, b, c;
    logic y1_r, y0_r;
    logic y1_c, y0_c;

    int checks;
    int failures;

    logic [1:0] rq[$];   // expected registered results, one per capture edge
    logic [1:0] cq[$];   // expected combinational results, one per input change
    event chg;

    assign_y0_y1 #(.REGISTERED(1'b1)) dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .Y1    (y1_r),
        .Y0    (y0_r)
    );

    assign_y0_y1 #(.REGISTERED(1'b0)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .Y1    (y1_c),
        .Y0    (y0_c)
    );

    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    function automatic logic [1:0] popcnt(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b at t=%0t", name, got, exp, $time);
        end
    endtask

    // Apply one vector just after a rising edge; queue both expectations.
    task automatic step(input logic [2:0] v, input logic [1:0] exp, input bit glitch);
        {a, b, c} = v;
        cq.push_back(exp);
        -> chg;
        if (glitch) begin
            #2 {a, b, c} = ~v;
            #3 {a, b, c} = v;
        end
        @(posedge clk);
        rq.push_back(rst_n ? exp : 2'b00);
        #5;
    endtask

    // Registered monitor: output is stable mid-cycle, after the capture edge.
    always @(negedge clk) begin
        if (rq.size() > 0) begin
            logic [1:0] e;
            e = rq.pop_front();
            check("reg_out", {y1_r, y0_r}, e);
        end
    end

    // Combinational monitor: output settles right after each input change.
    always @(chg) begin
        #1;
        if (cq.size() > 0) begin
            logic [1:0] e;
            e = cq.pop_front();
            check("comb_out", {y1_c, y0_c}, e);
        end
    end

    logic [2:0] gray [9];
    logic [1:0] gexp [9];

    initial begin
        checks   = 0;
        failures = 0;
        gray = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        gexp = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};

        // Reset held from time zero: outputs low before any clock edge.
        rst_n = 1'b0;
        {a, b, c} = 3'b101;
        #1;
        check("reset_no_clk", {y1_r, y0_r}, 2'b00);
        check("comb_in_reset", {y1_c, y0_c}, 2'b10);
        #3 {a, b, c} = 3'b111;
        #1;
        check("reset_hold_111", {y1_r, y0_r}, 2'b00);
        check("comb_in_reset_111", {y1_c, y0_c}, 2'b11);
        @(posedge clk);
        #1;
        check("reset_after_edge", {y1_r, y0_r}, 2'b00);
        #4 rst_n = 1'b1;
        #1;
        check("release_no_edge", {y1_r, y0_r}, 2'b00);

        // Gray sequence with hand-computed results.
        for (int i = 0; i < 9; i++) begin
            step(gray[i], gexp[i], 1'b0);
        end

        // Mid-sequence reset while the output shows 11.
        step(3'b111, 2'b11, 1'b0);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("async_clear", {y1_r, y0_r}, 2'b00);
        @(posedge clk);
        #1;
        check("clear_held", {y1_r, y0_r}, 2'b00);
        #4 rst_n = 1'b1;
        #1;
        check("no_stale_after_release", {y1_r, y0_r}, 2'b00);
        step(3'b111, 2'b11, 1'b0);

        // Random vectors against the popcount model, with mid-cycle glitches.
        for (int i = 0; i < 1000; i++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            step(v, popcnt(v), (i % 3) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rq.size() != 0 || cq.size() != 0) begin
            failures++;
            $display("FAIL drain rq=%0d cq=%0d expected=0", rq.size(), cq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_assign_y0_y1

// File: doc/assign_y0_y1.md
ASSIGN_Y0_Y1 -- requirements
Module: assign_y0_y1

Interface
REQ-001 Parameter REGISTERED, default 1, SHALL select the output path: 1 = registered outputs, 0 = purely combinational outputs.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port a, input, 1 bit: data input, most significant weight in test ordering.
REQ-005 Port b, input, 1 bit: data input.
REQ-006 Port c, input, 1 bit: data input, least significant weight in test ordering.
REQ-007 Port Y1, output, 1 bit: high bit of the result.
REQ-008 Port Y0, output, 1 bit: low bit of the result.
REQ-009 Positional port order SHALL be (clk, rst_n, a, b, c, Y1, Y0).

Function
REQ-010 {Y1,Y0} SHALL equal the count of ones among a, b and c, giving a range of 0..3 (full-adder sum/carry).
REQ-011 Y1 SHALL be the majority function: (a&b)|(a&c)|(b&c).
REQ-012 Y0 SHALL be the odd-parity function: a^b^c.
REQ-013 With REGISTERED=1, Y1/Y0 SHALL reflect the inputs sampled at the previous rising clk edge, a latency of exactly 1 cycle.
REQ-014 With REGISTERED=1, outputs SHALL hold their value between clock edges regardless of input glitches.
REQ-015 With REGISTERED=0, Y1/Y0 SHALL follow the inputs combinationally, and clk/rst_n SHALL have no effect.
REQ-016 The design SHALL have no handshake and no state beyond the two output flops; every input combination SHALL be valid on every cycle.
REQ-017 Inputs that are X/Z are not supported; behaviour for them is not required.

Reset
REQ-018 While rst_n=0 with REGISTERED=1, Y1 and Y0 SHALL be 0 immediately, without waiting for a clock edge.
REQ-019 Deassertion of rst_n SHALL take effect at the next rising clk edge, which captures the current inputs.
REQ-020 A reset asserted mid-sequence SHALL clear the outputs asynchronously, and no stale value SHALL reappear after release.

Structure
REQ-021 A shared package assign_y0_y1_pkg SHALL hold the result-width constant (2) and the reset value constant (2'b00).
REQ-022 A combinational sub-module maj_par3 (inputs a, b, c; outputs maj, par) SHALL compute REQ-011/REQ-012.
REQ-023 The top level SHALL only instantiate maj_par3 and add the optional register stage.

Verification
REQ-024 Hold rst_n=0, then apply any input -> Y1=0 and Y0=0 with no clock edge required.
REQ-025 With REGISTERED=1, apply the Gray sequence abc = 000, 001, 011, 010, 110, 111, 101, 100, 000, one vector per 50-time-unit clock period:
- Required {Y1,Y0} one cycle later: 00, 01, 10, 01, 10, 11, 10, 01, 00.
REQ-026 With REGISTERED=0, apply the same Gray sequence -> identical values with zero-cycle latency, checked 1 time unit after each change.
REQ-027 Assert rst_n=0 while abc=111 and {Y1,Y0}=11 -> outputs drop to 00 asynchronously; release rst_n -> 11 after one clock edge.
REQ-028 Apply exhaustive random stimulus over 1000 cycles -> a scoreboard computing popcount(a,b,c), delayed by 1 cycle, matches {Y1,Y0} every cycle.
